// File: rtl/regbank_pkg.sv
// Shared constants, FSM encoding and write payload type for the clearable MIPS register bank.
package regbank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [IDX_W-1:0]  REG_ZERO         = 5'd0;
  localparam logic [IDX_W-1:0]  REG_SP           = 5'd29;
  localparam logic [IDX_W-1:0]  REG_RA           = 5'd31;
  localparam logic [DATA_W-1:0] SP_RESET_DEFAULT = 32'd227;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } clr_wr_t;

  // Architectural reset value of one register: $sp gets the stack base, all others zero.
  function automatic logic [DATA_W-1:0] reset_image(input logic [IDX_W-1:0] idx,
                                                    input logic [DATA_W-1:0] sp_val);
    return (idx == REG_SP) ? sp_val : '0;
  endfunction

endpackage

// File: rtl/reg_bank_clearable_if.sv
// Control-unit / datapath bus into the register bank: write port, two read ports, bulk clear.
interface reg_bank_clearable_if;
  import regbank_pkg::*;

  logic              reg_write;
  logic [IDX_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic [IDX_W-1:0]  read_reg1;
  logic [IDX_W-1:0]  read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              clear_req;
  logic              busy;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2, clear_req,
    input  read_data1, read_data2, busy
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2, clear_req,
    output read_data1, read_data2, busy
  );

endinterface

// File: rtl/regbank_clear_seq.sv
// Bulk-clear sequencer: walks r1..r31 one per cycle, emitting the reset image of each register.
module regbank_clear_seq
  import regbank_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear_req_i,
  output logic    busy_o,
  output clr_wr_t clr_wr_o
);

  clr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Data is precomputed one cycle ahead so the clear write value leaves a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = IDX_W'(1);
          data_d  = reset_image(IDX_W'(1), SP_RESET);
        end
      end
      ST_CLEAR: begin
        cnt_d  = cnt_q + IDX_W'(1);
        data_d = reset_image(cnt_d, SP_RESET);
        if (cnt_q == REG_RA) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q == ST_CLEAR);
  assign clr_wr_o.we   = (state_q == ST_CLEAR);
  assign clr_wr_o.idx  = cnt_q;
  assign clr_wr_o.data = data_q;

endmodule

// File: rtl/reg_bank_clearable.sv
// 32x32 MIPS register bank, two async read ports, one write port, sequenced bulk clear.
// Optional write-to-read forwarding is compiled in with `define REGBANK_BYPASS_EN.
module reg_bank_clearable
  import regbank_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_bank_clearable_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  clr_wr_t           clr_wr;
  logic              busy;
  logic              wr_en_c;

  regbank_clear_seq #(
    .SP_RESET (SP_RESET)
  ) u_clear_seq (
    .clk         (clk),
    .rst_n       (reset),
    .clear_req_i (bus.clear_req),
    .busy_o      (busy),
    .clr_wr_o    (clr_wr)
  );

  // A clear request in the same cycle takes priority over a normal write.
  assign wr_en_c = bus.reg_write && !busy && !bus.clear_req && (bus.write_reg != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (clr_wr.we) begin
      regs_d[clr_wr.idx] = clr_wr.data;
    end else if (wr_en_c) begin
      regs_d[bus.write_reg] = bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= reset_image(IDX_W'(i), SP_RESET);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGBANK_BYPASS_EN
  logic byp_ok_c;
  assign byp_ok_c = bus.reg_write && !busy && (bus.write_reg != REG_ZERO);

  assign bus.read_data1 = (bus.read_reg1 == REG_ZERO) ? '0 :
                          (byp_ok_c && bus.write_reg == bus.read_reg1) ? bus.write_data :
                          regs_q[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == REG_ZERO) ? '0 :
                          (byp_ok_c && bus.write_reg == bus.read_reg2) ? bus.write_data :
                          regs_q[bus.read_reg2];
`else
  assign bus.read_data1 = (bus.read_reg1 == REG_ZERO) ? '0 : regs_q[bus.read_reg1];
  assign bus.read_data2 = (bus.read_reg2 == REG_ZERO) ? '0 : regs_q[bus.read_reg2];
`endif

  assign bus.busy = busy;

endmodule

// File: tb/tb_reg_bank_clearable.sv
// Self-checking bench for reg_bank_clearable: directed table, clear corner cases, random vs model.
module tb_reg_bank_clearable;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reg_bank_clearable_if bus ();

  reg_bank_clearable #(.SP_RESET(32'd227)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural contents plus the edge number at which a clear was accepted.
  logic [31:0] model [32];
  int          clr_start;
  int          edge_n;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t vecs [5];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
    clr_start = -1;
  endtask

  function automatic logic busy_m();
    return clr_start >= 0;
  endfunction

  // Register k of the reset image is restored k edges after the edge that accepted the clear.
  task automatic model_edge();
    int k;
    if (clr_start >= 0) begin
      k = edge_n - clr_start;
      model[k] = (k == 29) ? 32'd227 : 32'd0;
      if (k == 31) clr_start = -1;
    end else if (bus.clear_req) begin
      clr_start = edge_n;
    end else if (bus.reg_write && bus.write_reg != 5'd0) begin
      model[bus.write_reg] = bus.write_data;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGBANK_BYPASS_EN
    if (bus.reg_write && !busy_m() && bus.write_reg == idx) return bus.write_data;
`endif
    return model[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_model(input string name, input logic [4:0] a, input logic [4:0] b);
    bus.read_reg1 = a;
    bus.read_reg2 = b;
    #1;
    chk(name, bus.read_data1, exp_rd(a));
    chk(name, bus.read_data2, exp_rd(b));
  endtask

  task automatic rd_const(input string name, input logic [4:0] a, input logic [31:0] ea,
                          input logic [4:0] b, input logic [31:0] eb);
    bus.read_reg1 = a;
    bus.read_reg2 = b;
    #1;
    chk(name, bus.read_data1, ea);
    chk(name, bus.read_data2, eb);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    edge_n = 0;
    model_reset();

    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'h00400008, 5'd31, 5'd29, 32'h00400008, 32'd227};
    vecs[3] = '{1'b1, 5'd5,  32'd7,        5'd5,  5'd1,  32'd7,        32'h0};
    vecs[4] = '{1'b1, 5'd29, 32'd100,      5'd29, 5'd5,  32'd100,      32'd7};

    // Reset while clear and write are both requested
    reset          = 1'b0;
    bus.clear_req  = 1'b1;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd29;
    bus.write_data = 32'h5;
    bus.read_reg1  = 5'd29;
    bus.read_reg2  = 5'd1;
    #12;
    chk("reset_r29_r1", bus.read_data1, 32'd227);
    chk("reset_r29_r1", bus.read_data2, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rd_const("reset_r31", 5'd31, 32'd0, 5'd0, 32'd0);
    bus.clear_req = 1'b0;
    bus.reg_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      bus.reg_write  = vecs[i].we;
      bus.write_reg  = vecs[i].wr;
      bus.write_data = vecs[i].wd;
      tick();
      bus.reg_write = 1'b0;
      rd_const("table", vecs[i].r1, vecs[i].e1, vecs[i].r2, vecs[i].e2);
    end

    // Bulk clear with a write held from mid-clear and a re-request that must be ignored
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      n++;
      if (k == 5) begin
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd9;
        bus.write_data = 32'hAA;
      end
      if (k == 10) begin
        rd_const("mid_clear_partial", 5'd5, 32'd0, 5'd29, 32'd100);
        bus.clear_req = 1'b1;
      end
      if (k == 11) bus.clear_req = 1'b0;
      chk("clear_busy_model", 32'(bus.busy), 32'(busy_m()));
      tick();
    end
    chk("clear_busy_len", 32'(n), 32'd31);
    rd_const("after_clear", 5'd5, 32'd0, 5'd29, 32'd227);
    rd_const("after_clear_r31_r8", 5'd31, 32'd0, 5'd8, 32'd0);
    rd_model("after_clear_r9", 5'd9, 5'd0);
    tick();
    bus.reg_write = 1'b0;
    rd_const("first_write_e32", 5'd9, 32'hAA, 5'd0, 32'd0);

    // Clear and write collide in one cycle
    bus.clear_req  = 1'b1;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd3;
    bus.write_data = 32'd55;
    tick();
    bus.clear_req = 1'b0;
    bus.reg_write = 1'b0;
    chk("collide_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 40 && bus.busy; k++) tick();
    chk("collide_done", 32'(bus.busy), 32'd0);
    rd_const("collide_r3", 5'd3, 32'd0, 5'd29, 32'd227);

    // Reset asserted part-way through a clear
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd20;
    bus.write_data = 32'h77;
    tick();
    bus.write_reg  = 5'd29;
    bus.write_data = 32'd100;
    tick();
    bus.reg_write = 1'b0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (10) tick();
    rd_const("pre_reset_mid", 5'd20, 32'h77, 5'd29, 32'd100);
    reset = 1'b0;
    #1;
    chk("reset_mid_busy", 32'(bus.busy), 32'd0);
    rd_const("reset_mid_image", 5'd20, 32'd0, 5'd29, 32'd227);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("reset_mid_stays_idle", 32'(bus.busy), 32'd0);

    // Same-cycle read of a register being written
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd4;
    bus.write_data = 32'h11;
    tick();
    bus.write_data = 32'd9;
    bus.read_reg1  = 5'd4;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_pre_edge", bus.read_data1, 32'd9);
`else
    chk("bypass_pre_edge", bus.read_data1, 32'h11);
`endif
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("bypass_post_edge", bus.read_data1, 32'd9);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.reg_write  = 1'($urandom_range(0, 1));
      bus.write_reg  = 5'($urandom);
      bus.write_data = $urandom;
      bus.clear_req  = ($urandom_range(0, 39) == 0);
      rd_model("rand_rd", 5'($urandom), 5'($urandom));
      chk("rand_busy", 32'(bus.busy), 32'(busy_m()));
      tick();
    end
    bus.reg_write = 1'b0;
    bus.clear_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_clearable.md
# reg_bank_clearable

32 × 32-bit MIPS general-purpose register bank with two asynchronous read ports and one synchronous write port. It sits directly downstream of the write-register select mux: `write_reg` comes from that mux (rt / rd / $ra / $sp), and `read_data1`/`read_data2` feed the A/B latches of the multicycle datapath. It also has a sequenced bulk-clear operation, driven by the control unit, that returns the architectural state to its reset image without asserting global reset.

## Interface
- `SP_RESET`, default 227: value loaded into $sp (r29) at reset and on bulk clear.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: asynchronous, active-low.
- `reg_write` input, 1: write enable for the current cycle.
- `write_reg` input, 5: destination index, from the write-register mux.
- `write_data` input, 32: write value.
- `read_reg1` input, 5: port 1 index (rs).
- `read_reg2` input, 5: port 2 index (rt).
- `read_data1` output, 32: port 1 data.
- `read_data2` output, 32: port 2 data.
- `clear_req` input, 1: single-cycle request to start a bulk clear.
- `busy` output, 1: high while the bulk clear is in progress.

## Operation
- Reset (`reset`=0, asynchronous):
  - all registers are set to 0, except r29, which is set to `SP_RESET`;
  - the FSM goes to IDLE and `busy`=0.
- Reads are combinational.
  - An index of 0 always returns 32'h0.
  - Any other index returns the stored value, or the bypassed value when the macro in Configuration is compiled in.
- Writes:
  - A write occurs on the rising edge when `reg_write`=1, `write_reg`≠0 and the FSM is in IDLE.
  - A write to r0 is discarded.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on `clear_req`=1. The 5-bit counter is loaded with 1.
  - In CLEAR, on each edge, register[counter] is written with 0 (or with `SP_RESET` when counter=29), then the counter increments.
  - CLEAR→IDLE on the edge that writes r31.
- Boundary and priority rules:
  - `clear_req` and `reg_write` asserted in the same IDLE cycle: the clear wins and the write is dropped.
  - `reg_write` while `busy`=1: ignored, with no error flag. The control unit must not issue writes during a clear.
  - `clear_req` while `busy`=1: ignored. The sequence is not restarted.
  - Reads during CLEAR return the current array contents, so registers are partially cleared part-way through the sequence.
  - `reset` asserted mid-clear: immediate full reset image, IDLE, `busy`=0.

## Timing
- Write latency: the value is visible on the read ports after the same rising edge that performs the write. No bypass is applied unless the macro is compiled in.
- Read: purely combinational, with zero latency from index to data.
- Bulk clear:
  - `clear_req` is sampled at edge E0.
  - `busy`=1 from after E0 until after edge E31.
  - Registers r1..r31 are written at edges E1..E31, one per edge. The clear therefore takes 31 cycles.
- The first accepted write after a clear is at edge E32, provided `reg_write` is held.

## Configuration
- `REGBANK_BYPASS_EN` defined:
  - If `reg_write`=1, the FSM is in IDLE, `write_reg`≠0 and `write_reg` equals a port's read index, that port returns `write_data` combinationally in the same cycle (write-to-read forwarding).
  - r0 is never bypassed.
- `REGBANK_BYPASS_EN` undefined: reads always return the array contents. There is no forwarding path.

## Structure
- Shared package `regbank_pkg` holds:
  - index constants `REG_ZERO`=0, `REG_SP`=29, `REG_RA`=31;
  - the FSM state encoding (IDLE=1'b0, CLEAR=1'b1);
  - the default `SP_RESET` value.
- One sub-module, `regbank_clear_seq`, contains the IDLE/CLEAR FSM, the 5-bit counter and `busy`. It outputs the clear write enable, index and data.
- The top level muxes between the clear writes and the normal writes and owns the storage array and the read ports.

## Test plan
- Reset: assert `reset`=0 while `clear_req`=1 and `reg_write`=1. Required: r29 reads 227, r1/r31 read 0, `busy`=0.
- Write/read: write 32'hDEADBEEF to r8, then read r8 on port 1 and r0 on port 2 the next cycle. Required: port 1 = DEADBEEF, port 2 = 0.
  - A write of 32'h1234 to r0 must leave port reads of r0 at 0.
- $ra write: `write_reg`=31 with data 32'h0040_0008. Required: r31 = 0040_0008 after the edge.
- Bulk clear: preload r5=7 and r29=100, pulse `clear_req`.
  - Required: `busy` is high for exactly 31 cycles, a `reg_write` to r9 during the clear is dropped, and after the clear r5=0, r29=227, r9=0.
- Collision: `clear_req` and a `reg_write` of 55 to r3 in the same cycle. Required: the clear starts and r3 ends at 0.
  - Separately, assert `reset` at cycle 10 of a clear. Required: `busy` falls immediately and the reset image is restored.
- Bypass (`REGBANK_BYPASS_EN` defined): `reg_write`=1, `write_reg`=4, `write_data`=9, `read_reg1`=4. Required: `read_data1`=9 before the edge.
  - With the macro undefined, `read_data1` shows the old value of r4 before the edge.
